// File: rtl/rpsc_ff_card.sv
// rpsc_ff_card - parametrised RPSC flip-flop card.
//
// Each of NCH asynchronous trip inputs is synchronised (2 flops), debounced
// (DEBOUNCE consecutive stable cycles) and latched into a lamp/alarm output.
// A latch holds until an acknowledge arrives while its filtered input is
// inactive. The card also drives EP relays on mask-selected channels, a lamp
// test, a summary trip and a first-out capture of the earliest channel.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   in_i          in   [NCH]  raw trip inputs (1 = trip), asynchronous
//   ack_i         in   operator acknowledge (level-sensitive, sync)
//   lamp_test_i   in   forces all la_o high while asserted
//   la_o          out  [NCH]  latched alarm lamps (latch | lamp test)
//   ep_o          out  [NCH]  EP relay outputs (latch & EP_MASK)
//   trip_any_o    out  OR of all latches
//   first_out_o   out  [FOW]  index of the first channel to latch
//   first_valid_o out  first_out_o holds a valid capture

module rpsc_ff_card #(
    parameter int unsigned    NCH      = 8,
    parameter int unsigned    DEBOUNCE = 4,
    parameter logic [NCH-1:0] EP_MASK  = NCH'(8'b0010_0010),
    parameter int unsigned    FOW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] in_i,
    input  logic           ack_i,
    input  logic           lamp_test_i,
    output logic [NCH-1:0] la_o,
    output logic [NCH-1:0] ep_o,
    output logic           trip_any_o,
    output logic [FOW-1:0] first_out_o,
    output logic           first_valid_o
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE + 1);
    // Counter value on which the next mismatching cycle commits the new state.
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE - 1);

    logic [NCH-1:0] s1_q, s2_q;
    logic [NCH-1:0] filt_q, filt_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] latch_q, latch_d;
    logic [NCH-1:0] set_vec, clr_vec;
    logic [FOW-1:0] fo_q, fo_d, fo_sel;
    logic           fv_q, fv_d;

    // Debounce: count cycles where the synchronised input disagrees with the
    // filtered state; any agreement restarts the count.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            if (s2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Latch sets on the same edge the filtered state rises; set beats ack.
    always_comb begin
        set_vec = filt_d & ~filt_q;
        clr_vec = {NCH{ack_i}} & ~filt_q;
        latch_d = set_vec | (latch_q & ~clr_vec);
    end

    // Lowest index among channels setting on this edge.
    always_comb begin
        fo_sel = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (set_vec[i]) begin
                fo_sel = FOW'(i);
            end
        end
    end

    // First-out: capture once, then frozen until an ack leaves no latch set.
    always_comb begin
        fo_d = fo_q;
        fv_d = fv_q;
        if (!fv_q && (|set_vec)) begin
            fo_d = fo_sel;
            fv_d = 1'b1;
        end else if (ack_i && (latch_d == '0)) begin
            fo_d = '0;
            fv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            filt_q  <= '0;
            latch_q <= '0;
            fo_q    <= '0;
            fv_q    <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= in_i;
            s2_q    <= s1_q;
            filt_q  <= filt_d;
            latch_q <= latch_d;
            fo_q    <= fo_d;
            fv_q    <= fv_d;
            for (int i = 0; i < int'(NCH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign la_o          = latch_q | {NCH{lamp_test_i}};
    assign ep_o          = latch_q & EP_MASK;
    assign trip_any_o    = |latch_q;
    assign first_out_o   = fo_q;
    assign first_valid_o = fv_q;

endmodule

// File: tb/tb_rpsc_ff_card.sv
module tb_rpsc_ff_card;

    logic       clk;
    logic       reset;
    logic [7:0] in_i;
    logic       ack_i;
    logic       lamp_test_i;
    logic [7:0] la_o;
    logic [7:0] ep_o;
    logic       trip_any_o;
    logic [2:0] first_out_o;
    logic       first_valid_o;

    int n_assert = 0;
    int n_fail   = 0;

    rpsc_ff_card #(
        .NCH      (8),
        .DEBOUNCE (4),
        .EP_MASK  (8'b0010_0010),
        .FOW      (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_i          (in_i),
        .ack_i         (ack_i),
        .lamp_test_i   (lamp_test_i),
        .la_o          (la_o),
        .ep_o          (ep_o),
        .trip_any_o    (trip_any_o),
        .first_out_o   (first_out_o),
        .first_valid_o (first_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; leave time 1 unit after it for sampling/driving.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ack_pulse();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_i        = 8'h00;
        ack_i       = 1'b0;
        lamp_test_i = 1'b0;
        tick(3);
        check("rst_la", 32'(la_o), 32'h00);
        check("rst_ep", 32'(ep_o), 32'h00);
        check("rst_trip", 32'(trip_any_o), 32'h0);
        check("rst_fv", 32'(first_valid_o), 32'h0);
        check("rst_fo", 32'(first_out_o), 32'h0);
        reset = 1'b0;

        // Latency: first sampling edge is edge 1; lamp rises on edge 6.
        in_i = 8'h08;
        tick(5);
        check("lat_before", 32'(la_o), 32'h00);
        tick();
        check("lat_la", 32'(la_o), 32'h08);
        check("lat_trip", 32'(trip_any_o), 32'h1);
        check("lat_fo", 32'(first_out_o), 32'h3);
        check("lat_fv", 32'(first_valid_o), 32'h1);
        check("lat_ep", 32'(ep_o), 32'h00);
        in_i = 8'h00;
        tick(8);
        check("lat_held", 32'(la_o), 32'h08);
        ack_pulse();
        check("lat_clr_la", 32'(la_o), 32'h00);
        check("lat_clr_fv", 32'(first_valid_o), 32'h0);

        // Glitch of 3 cycles is rejected, 4 cycles is accepted.
        in_i = 8'h02;
        tick(3);
        in_i = 8'h00;
        tick(8);
        check("glitch3_la", 32'(la_o), 32'h00);
        check("glitch3_fv", 32'(first_valid_o), 32'h0);
        in_i = 8'h02;
        tick(4);
        in_i = 8'h00;
        tick(8);
        check("glitch4_la", 32'(la_o), 32'h02);
        check("glitch4_ep", 32'(ep_o), 32'h02);
        check("glitch4_fo", 32'(first_out_o), 32'h1);
        ack_pulse();
        check("glitch4_clr", 32'(la_o), 32'h00);

        // Ack while input still active must not clear.
        in_i = 8'h20;
        tick(8);
        check("ack_set_la", 32'(la_o), 32'h20);
        ack_pulse();
        check("ack_hold_la", 32'(la_o), 32'h20);
        check("ack_hold_ep", 32'(ep_o), 32'h20);
        check("ack_hold_fv", 32'(first_valid_o), 32'h1);
        check("ack_hold_fo", 32'(first_out_o), 32'h5);
        in_i = 8'h00;
        tick(6);
        check("ack_wait_la", 32'(la_o), 32'h20);
        ack_pulse();
        check("ack_clr_la", 32'(la_o), 32'h00);
        check("ack_clr_trip", 32'(trip_any_o), 32'h0);
        check("ack_clr_fv", 32'(first_valid_o), 32'h0);

        // First-out ordering.
        in_i = 8'h44;
        tick(8);
        check("fo_la1", 32'(la_o), 32'h44);
        check("fo_idx1", 32'(first_out_o), 32'h2);
        in_i = 8'h45;
        tick(8);
        check("fo_la2", 32'(la_o), 32'h45);
        check("fo_idx2", 32'(first_out_o), 32'h2);
        check("fo_ep", 32'(ep_o), 32'h00);
        in_i = 8'h00;
        tick(8);
        ack_pulse();
        check("fo_clr_la", 32'(la_o), 32'h00);
        check("fo_clr_fo", 32'(first_out_o), 32'h0);

        // Lamp test is combinational and touches only la_o.
        lamp_test_i = 1'b1;
        #1;
        check("lt_la", 32'(la_o), 32'hFF);
        check("lt_ep", 32'(ep_o), 32'h00);
        check("lt_trip", 32'(trip_any_o), 32'h0);
        lamp_test_i = 1'b0;
        #1;
        check("lt_off_la", 32'(la_o), 32'h00);
        tick();

        // Async reset mid-debounce discards latched and partial state.
        in_i = 8'h80;
        tick(8);
        check("rr_pre_la", 32'(la_o), 32'h80);
        in_i = 8'h10;
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check("rr_la", 32'(la_o), 32'h00);
        check("rr_trip", 32'(trip_any_o), 32'h0);
        check("rr_fv", 32'(first_valid_o), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("rr_before", 32'(la_o), 32'h00);
        tick();
        check("rr_lat_la", 32'(la_o), 32'h10);
        check("rr_lat_fo", 32'(first_out_o), 32'h4);
        check("rr_lat_fv", 32'(first_valid_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rpsc_ff_card.md
Name: rpsc_ff_card

Overview:
- Parametrised RPSC flip-flop card. Replaces the fixed 8-channel per-card modules.
- Each of NCH trip inputs is synchronised, debounced and latched into a lamp/alarm output (LA).
- Latched trips are held until an operator acknowledge, provided the input has returned inactive.
- Adds an EP relay output on mask-selected channels, a lamp test, a summary trip, and first-out capture of the earliest tripping channel.

Parameters:
- NCH, 8, number of flip-flop channels (1..32).
- DEBOUNCE, 4, consecutive stable cycles required to change the filtered state (>=1).
- EP_MASK, 8'b0010_0010, per-channel enable for ep_o; bit i enables channel i. Width NCH.
- FOW, $clog2(NCH) (min 1), width of first_out_o.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_i  in  NCH  raw trip inputs, asynchronous to clk; 1 = trip.
- ack_i  in  1  operator acknowledge, synchronous single-cycle pulse.
- lamp_test_i  in  1  synchronous; forces all la_o high while asserted.
- la_o  out  NCH  latched alarm lamp per channel.
- ep_o  out  NCH  EP relay output; latch AND EP_MASK.
- trip_any_o  out  1  OR of all channel latches.
- first_out_o  out  FOW  index of the first channel to latch.
- first_valid_o  out  1  first_out_o holds a valid capture.

Behaviour:
- Reset is asynchronous, active-high. On reset, all of the following clear to 0: sync flops, debounce counters, filtered states, latches, first_out_o, first_valid_o. Hence la_o=0, ep_o=0, trip_any_o=0.
- Reset mid-operation discards all latched and partially counted state. No trip survives reset.
- Synchroniser: each channel has a 2-flop chain s1 -> s2.
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE+1). filt resets to 0.
  - When s2 != filt: counter increments; on the edge it reaches DEBOUNCE, filt <= s2 and the counter clears.
  - When s2 == filt: counter clears.
  - Any glitch shorter than DEBOUNCE cycles at s2 is rejected.
- Latency: if in_i rises and holds, la_o rises DEBOUNCE+2 clock edges after the first edge that samples in_i high.
- Latch, per channel:
  - Set on the edge where filt transitions 0->1.
  - Held regardless of input until cleared.
  - Cleared only on an edge where ack_i=1 AND filt=0 (input stable inactive).
  - If ack_i arrives while filt=1, that channel is not cleared; it requires a later ack.
  - Simultaneous set and ack on the same channel: set wins.
- la_o = latch | {NCH{lamp_test_i}}. Combinational from registered latch; no extra cycle.
- ep_o = latch & EP_MASK. lamp_test_i never drives ep_o.
- trip_any_o = |latch. lamp_test_i does not affect it.
- First-out capture:
  - When first_valid_o=0 and one or more latches set on an edge, first_out_o <= lowest index among the channels setting on that edge, and first_valid_o <= 1.
  - While first_valid_o=1, first_out_o is frozen.
  - first_valid_o and first_out_o clear to 0 on the edge where ack_i=1 and, after that edge's clears, no latch remains set.
  - If a new set occurs on that same edge, treat the latch as remaining set: first_valid_o stays 1 and first_out_o is unchanged.
- ack_i held high for multiple cycles behaves as repeated acks (level-sensitive). Lamp test and ack are independent.

Test Plan:
- Latency and latch: NCH=8, DEBOUNCE=4, reset released; in_i[3] 0->1 held -> la_o[3]=1 exactly 6 edges after first sampling edge; trip_any_o=1; first_out_o=3, first_valid_o=1; ep_o=0x00.
- Glitch rejection: in_i[1] high for 3 cycles then low -> la_o stays 0x00, first_valid_o=0. Repeat with 4 cycles -> la_o[1]=1, ep_o[1]=1 (EP_MASK default).
- Ack rules: ch5 latched with in_i[5] still high, ack pulse -> la_o[5] stays 1, ep_o[5]=1. Drop in_i[5], wait DEBOUNCE+2, ack -> la_o=0x00, trip_any_o=0, first_valid_o=0.
- First-out ordering: in_i[6] and in_i[2] rise on the same edge -> first_out_o=2. Then in_i[0] rises -> first_out_o stays 2, la_o=0x45.
- Lamp test: no trips, lamp_test_i=1 -> la_o=0xFF, ep_o=0x00, trip_any_o=0. Release -> la_o=0x00 the same cycle.
- Async reset mid-debounce: in_i[4] high for 2 cycles, then assert reset between edges -> all outputs 0 immediately. Deassert with in_i[4] still high -> la_o[4] rises DEBOUNCE+2 edges after the first sampling edge following reset release.
